// File: rtl/ring_nic_if.sv
// Processor register bus and router handshake of the ring NIC, grouped into one bundle.
// The NIC side uses the slave modport; the processor/router side uses master.
interface ring_nic_if #(
    parameter int PAC_SIZE = 64
);
    logic                polarity;
    logic [1:0]          addr;
    logic [PAC_SIZE-1:0] d_in;
    logic [PAC_SIZE-1:0] d_out;
    logic                nicEn;
    logic                nicWrEn;
    logic                net_si;
    logic                net_ro;
    logic [PAC_SIZE-1:0] net_di;
    logic                net_so;
    logic                net_ri;
    logic [PAC_SIZE-1:0] net_do;

    modport master (
        output polarity, addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ri,
        input  d_out, net_ro, net_so, net_do
    );

    modport slave (
        input  polarity, addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ri,
        output d_out, net_ro, net_so, net_do
    );
endinterface

// File: rtl/ring_nic_ctrl.sv
// Ring network interface: one-deep output buffer injected on the matching ring
// polarity, one-deep input buffer drained by a read-to-clear of register 0.
module ring_nic_ctrl #(
    parameter int PAC_SIZE = 64
) (
    input logic         clk,
    input logic         reset,
    ring_nic_if.slave   bus
);
    logic [PAC_SIZE-1:0] out_buf;
    logic [PAC_SIZE-1:0] in_buf;
    logic                out_full;
    logic                in_full;

    logic rd_en;
    logic wr_out;
    logic rd_clear;
    logic send;
    logic capture;

    assign rd_en    = bus.nicEn & ~bus.nicWrEn;
    // A write into a full output buffer is dropped, even if it drains this cycle.
    assign wr_out   = bus.nicEn & bus.nicWrEn & (bus.addr == 2'd2) & ~out_full;
    assign rd_clear = rd_en & (bus.addr == 2'd0) & in_full;
    assign send     = out_full & bus.net_ri & (out_buf[PAC_SIZE-1] == bus.polarity);
    assign capture  = bus.net_si & ~in_full;

    assign bus.net_so = send;
    assign bus.net_do = out_buf;
    assign bus.net_ro = ~in_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            in_buf   <= '0;
            in_full  <= 1'b0;
        end else begin
            if (wr_out) begin
                out_buf  <= bus.d_in;
                out_full <= 1'b1;
            end else if (send) begin
                out_full <= 1'b0;
            end

            if (capture) begin
                in_buf  <= bus.net_di;
                in_full <= 1'b1;
            end else if (rd_clear) begin
                in_full <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.d_out = '0;
        if (rd_en) begin
            case (bus.addr)
                2'd0:    bus.d_out = in_buf;
                2'd1:    bus.d_out = {{(PAC_SIZE-1){1'b0}}, in_full};
                2'd2:    bus.d_out = out_buf;
                default: bus.d_out = {{(PAC_SIZE-1){1'b0}}, out_full};
            endcase
        end
    end
endmodule
